// File: rtl/jedro_1_defines.sv
// Shared types and constants for the jedro_1 instruction-memory arbiter.
package jedro_1_defines;

   localparam int unsigned DATA_WIDTH_DEFAULT            = 32;
   localparam int unsigned IMEM_ARB_STARVE_LIMIT_DEFAULT = 4;
   localparam int unsigned STARVE_CNT_WIDTH              = 4;

   typedef enum logic {
      ARB_NORMAL,
      ARB_LOCK
   } arb_state_e;

   typedef enum logic {
      PORT_IFU,
      PORT_LSU
   } arb_port_e;

   // Records which port owns the read currently in flight.
   typedef struct packed {
      logic      valid;
      arb_port_e port;
   } arb_owner_t;

endpackage

// File: rtl/jedro_1_sat_counter.sv
// Saturating up-counter with clear (highest priority), hold and increment controls.
module jedro_1_sat_counter #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned LIMIT = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             hold_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] cnt_o
);

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         cnt_o <= '0;
      end else if (hold_i) begin
         cnt_o <= cnt_o;
      end else if (inc_i && (cnt_o != WIDTH'(LIMIT))) begin
         cnt_o <= cnt_o + WIDTH'(1);
      end
   end

endmodule

// File: rtl/jedro_1_imem_arbiter.sv
// Arbitrates the single-port instruction SPROM between IFU and LSU, with LSU lock and IFU starvation guard.
// Optional conflict statistics counter enabled by defining JEDRO_1_IMEM_ARB_STATS_EN.
module jedro_1_imem_arbiter
   import jedro_1_defines::*;
#(
   parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEFAULT,
   parameter int unsigned STARVE_LIMIT = IMEM_ARB_STARVE_LIMIT_DEFAULT
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  ifu_req_i,
   input  logic [DATA_WIDTH-1:0] ifu_addr_i,
   output logic                  ifu_gnt_o,
   output logic                  ifu_rvalid_o,
   output logic [DATA_WIDTH-1:0] ifu_rdata_o,
   input  logic                  lsu_req_i,
   input  logic [DATA_WIDTH-1:0] lsu_addr_i,
   input  logic                  lsu_lock_i,
   output logic                  lsu_gnt_o,
   output logic                  lsu_rvalid_o,
   output logic [DATA_WIDTH-1:0] lsu_rdata_o,
   output logic                  mem_en_o,
   output logic [DATA_WIDTH-1:0] mem_addr_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
`ifdef JEDRO_1_IMEM_ARB_STATS_EN
   ,
   output logic [31:0]           conflict_cnt_o
`endif
);

   arb_state_e                  state_q, state_d;
   arb_owner_t                  owner_q, owner_d;
   logic [STARVE_CNT_WIDTH-1:0] starve_cnt;
   logic                        locked_c;
   logic                        starve_hit_c;

   // Lock only holds while the line stays high; the release cycle already arbitrates normally.
   assign locked_c     = (state_q == ARB_LOCK) && lsu_lock_i;
   assign starve_hit_c = (starve_cnt == STARVE_CNT_WIDTH'(STARVE_LIMIT));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ARB_NORMAL;
         owner_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
      end
   end

   always_comb begin
      ifu_gnt_o = 1'b0;
      lsu_gnt_o = 1'b0;
      state_d   = state_q;
      if (!rst_i) begin
         if (locked_c) begin
            lsu_gnt_o = lsu_req_i;
         end else if (ifu_req_i && lsu_req_i) begin
            ifu_gnt_o = starve_hit_c;
            lsu_gnt_o = !starve_hit_c;
         end else begin
            ifu_gnt_o = ifu_req_i;
            lsu_gnt_o = lsu_req_i;
         end
      end
      case (state_q)
         ARB_NORMAL: if (lsu_gnt_o && lsu_lock_i) state_d = ARB_LOCK;
         ARB_LOCK:   if (!lsu_lock_i)             state_d = ARB_NORMAL;
         default:                                 state_d = ARB_NORMAL;
      endcase
   end

   always_comb begin
      owner_d.valid = ifu_gnt_o || lsu_gnt_o;
      owner_d.port  = ifu_gnt_o ? PORT_IFU : PORT_LSU;
   end

   assign mem_en_o   = ifu_gnt_o || lsu_gnt_o;
   assign mem_addr_o = ifu_gnt_o ? ifu_addr_i : (lsu_gnt_o ? lsu_addr_i : '0);

   // A read in flight when reset hits is dropped.
   assign ifu_rvalid_o = !rst_i && owner_q.valid && (owner_q.port == PORT_IFU);
   assign lsu_rvalid_o = !rst_i && owner_q.valid && (owner_q.port == PORT_LSU);
   assign ifu_rdata_o  = ifu_rvalid_o ? mem_rdata_i : '0;
   assign lsu_rdata_o  = lsu_rvalid_o ? mem_rdata_i : '0;

   jedro_1_sat_counter #(
      .WIDTH (STARVE_CNT_WIDTH),
      .LIMIT (STARVE_LIMIT)
   ) u_starve_cnt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (!ifu_req_i || ifu_gnt_o),
      .hold_i (locked_c),
      .inc_i  (ifu_req_i && !ifu_gnt_o),
      .cnt_o  (starve_cnt)
   );

`ifdef JEDRO_1_IMEM_ARB_STATS_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         conflict_cnt_o <= '0;
      end else if (ifu_req_i && (lsu_req_i || (state_q == ARB_LOCK))) begin
         conflict_cnt_o <= conflict_cnt_o + 32'd1;
      end
   end
`endif

endmodule
